mm_addr_decoder_n: RTL and testbench
====================================

# mm_addr_decoder_n

Parametrised memory-mapped address decoder for the link register bus. It registers host requests, routes reads and writes to one of NUM_CH downstream register blocks by the top SEL_W address bits, and returns read data to the host. It also tracks the single outstanding read, times out reads a channel never answers, answers unmapped reads with a signature word, and counts error events. It sits between the host MM bus and the per-link and per-channel register blocks.

## Interface
- NUM_CH, 4: number of downstream channels, 1..2^SEL_W.
- AW, 17: address width.
- DW, 64: data width, at least 64.
- SEL_W, 3: channel-select field width, taken from addr[AW-1 -: SEL_W].
- TIMEOUT, 255: maximum read wait in cycles, 2..65535.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- iMM_WR_EN / iMM_RD_EN  in  1  host write / read strobe, one cycle per access.
- iMM_ADDR  in  AW  host address.
- iMM_WR_DATA  in  DW  host write data.
- oMM_RD_DATA  out  DW  read response data.
- oMM_RD_DATA_V  out  1  read response valid, one-cycle pulse.
- oMM_BUSY  out  1  high while a read is outstanding (FSM in WAIT).
- oCH_ADDR  out  AW  registered address, shared by all channels.
- oCH_WR_DATA  out  DW  registered write data, shared.
- oCH_WR_EN / oCH_RD_EN  out  NUM_CH  one-hot per-channel strobes.
- iCH_RD_DATA  in  NUM_CH*DW  channel read data; channel i occupies bits [i*DW +: DW].
- iCH_RD_DATA_V  in  NUM_CH  per-channel read valid.
- oERR_TIMEOUT_CNT / oERR_UNMAPPED_CNT / oERR_DROP_CNT  out  16  saturating error counters.

## Operation
- **Request stage:** iMM_* is registered every cycle into laddr, lwen, lren and lwdata. sel = laddr[AW-1 -: SEL_W]. The access is mapped when sel < NUM_CH.
- **Write:** when lwen is high and the access is mapped, oCH_WR_EN[sel] = 1 for that cycle. Writes are forwarded in any FSM state. An unmapped write is discarded and oERR_UNMAPPED_CNT increments.
- **Read-write conflict:** if lwen and lren are high together, the write proceeds, the read is dropped, and oERR_DROP_CNT increments.
- **Read in IDLE, mapped:** oCH_RD_EN[sel] = 1 and the target is latched into cur_sel.
  - If iCH_RD_DATA_V[sel] is also high that cycle, the data is captured and the FSM stays in IDLE.
  - Otherwise the FSM enters WAIT with wait_cnt = 1.
- **Read in IDLE, unmapped:** the response word is {32'h5555_AAAA, zero-pad, laddr}. oERR_UNMAPPED_CNT increments. No strobe is issued.
- **WAIT state:**
  - iCH_RD_DATA_V[cur_sel] captures the data and returns the FSM to IDLE.
  - Otherwise wait_cnt increments. When wait_cnt reaches TIMEOUT, the response word is {32'hDEAD_BEEF, zero-pad, laddr of the read}, oERR_TIMEOUT_CNT increments, and the FSM returns to IDLE.
  - Any lren arriving while in WAIT is dropped: no strobe, no response, and oERR_DROP_CNT increments.
- **Valid filtering:** iCH_RD_DATA_V from non-selected channels, and any valid while in IDLE with no read issued that cycle, is ignored. A late response arriving after a timeout is therefore discarded.
- **Response output:** every captured or generated response word drives oMM_RD_DATA, with oMM_RD_DATA_V = 1, on the next cycle. oMM_RD_DATA holds its value between responses.
- **Counters:** each counter increments by at most 1 per cycle and saturates at 16'hFFFF.

## Timing
- Reset value of every output: oMM_RD_DATA, oMM_RD_DATA_V, oMM_BUSY, all strobes, oCH_ADDR, oCH_WR_DATA and all three counters are 0. The FSM resets to IDLE.
- Reset asserted mid-WAIT aborts the read. No response is ever issued for it.
- Host strobe at cycle 0 → the channel strobe, oCH_ADDR and oCH_WR_DATA are valid in cycle 1.
- Channel valid at cycle k (k ≥ 1) → oMM_RD_DATA_V at cycle k+1. The minimum read latency is 2 cycles.
- Unmapped read → oMM_RD_DATA_V at cycle 2.
- No valid in cycles 1..TIMEOUT → the timeout response arrives at cycle TIMEOUT+1. A valid arriving exactly at cycle TIMEOUT wins over the timeout.
- oMM_BUSY is high from cycle 2 until the cycle after the valid or timeout. A new read registered in that same cycle is accepted.
- At most one read is outstanding. Responses are always delivered in request order.

## Test plan
- **Write to channel 2:** write to addr 17'h08010 (sel 2) with data 64'h1234 → oCH_WR_EN = 4'b0100 at cycle 1, oCH_ADDR = 17'h08010, oCH_WR_DATA = 64'h1234. No read valid is produced.
- **Reads on channels 0 and 3:** read on ch0 with the channel responding at cycle 3 with 64'hA5 → oMM_RD_DATA_V at cycle 4 with 64'hA5. Repeat on ch3 with a same-cycle response at cycle 1 → valid at cycle 2.
- **Unmapped read:** read to addr 17'h1C005 (sel 7, NUM_CH = 4) → valid at cycle 2 with data {32'h5555_AAAA, 15'b0, 17'h1C005}, and oERR_UNMAPPED_CNT = 1.
- **Timeout:** with TIMEOUT = 8, read ch1 and withhold valid → response at cycle 9 with data {32'hDEAD_BEEF, 15'b0, addr}, oERR_TIMEOUT_CNT = 1. A late ch1 valid at cycle 12 produces no output.
- **Drop and conflict:** issue a second read while ch0 is outstanding → no strobe and oERR_DROP_CNT = 1, while the first read completes normally. Then assert wr and rd together → the write is strobed and oERR_DROP_CNT = 2.
- **Reset in WAIT:** assert rst_n low during WAIT → all outputs read 0, and there is no response after release even if the channel valid arrives.

Source files
------------

// File: rtl/mm_addr_decoder_n.sv
// mm_addr_decoder_n: registers host MM requests and routes them to NUM_CH register blocks by the top address bits
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   iMM_WR_EN/iMM_RD_EN    host write/read strobes; iMM_ADDR, iMM_WR_DATA host address/data
//   oMM_RD_DATA(_V)        read response word and one-cycle valid; oMM_BUSY high while a read waits
//   oCH_ADDR, oCH_WR_DATA  registered address/write data shared by every channel
//   oCH_WR_EN/oCH_RD_EN    one-hot per-channel strobes
//   iCH_RD_DATA(_V)        per-channel read data (channel i at [i*DW +: DW]) and valid
//   oERR_*_CNT             saturating timeout / unmapped / dropped-read counters
module mm_addr_decoder_n #(
  parameter int NUM_CH  = 4,
  parameter int AW      = 17,
  parameter int DW      = 64,
  parameter int SEL_W   = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 iMM_WR_EN,
  input  logic                 iMM_RD_EN,
  input  logic [AW-1:0]        iMM_ADDR,
  input  logic [DW-1:0]        iMM_WR_DATA,
  output logic [DW-1:0]        oMM_RD_DATA,
  output logic                 oMM_RD_DATA_V,
  output logic                 oMM_BUSY,
  output logic [AW-1:0]        oCH_ADDR,
  output logic [DW-1:0]        oCH_WR_DATA,
  output logic [NUM_CH-1:0]    oCH_WR_EN,
  output logic [NUM_CH-1:0]    oCH_RD_EN,
  input  logic [NUM_CH*DW-1:0] iCH_RD_DATA,
  input  logic [NUM_CH-1:0]    iCH_RD_DATA_V,
  output logic [15:0]          oERR_TIMEOUT_CNT,
  output logic [15:0]          oERR_UNMAPPED_CNT,
  output logic [15:0]          oERR_DROP_CNT
);
  typedef enum logic {IDLE, WAIT} state_e;
  state_e            state_q, state_d;
  logic [AW-1:0]     laddr_q, rd_addr_q, rd_addr_d;
  logic              lwen_q, lren_q;
  logic [DW-1:0]     lwdata_q, rd_data_q, rd_data_d;
  logic              rd_v_q, rd_v_d;
  logic [SEL_W-1:0]  sel, cur_sel_q, cur_sel_d;
  logic [15:0]       wait_cnt_q, wait_cnt_d;
  logic [15:0]       to_cnt_q, um_cnt_q, dr_cnt_q;
  logic [NUM_CH-1:0] sel_oh;
  logic [DW-1:0]     sel_data, cur_data;
  logic              sel_v, cur_v, mapped, rd_ok, rd_go, inc_to, inc_um, inc_dr;
  function automatic logic [DW-1:0] resp_word(input logic [31:0] sig, input logic [AW-1:0] a);
    resp_word = '0;
    resp_word[DW-1 -: 32] = sig;
    resp_word[AW-1:0] = a;
  endfunction
  function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic inc);
    sat_inc = (inc && c != 16'hFFFF) ? c + 16'd1 : c;
  endfunction
  assign sel = laddr_q[AW-1 -: SEL_W];
  // Channel muxes: the freshly decoded target and the target of the outstanding read.
  always_comb begin
    sel_oh   = '0;
    sel_data = '0;
    sel_v    = 1'b0;
    cur_data = '0;
    cur_v    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_oh[i] = (sel == SEL_W'(i));
      if (sel == SEL_W'(i)) begin
        sel_data = iCH_RD_DATA[i*DW +: DW];
        sel_v    = iCH_RD_DATA_V[i];
      end
      if (cur_sel_q == SEL_W'(i)) begin
        cur_data = iCH_RD_DATA[i*DW +: DW];
        cur_v    = iCH_RD_DATA_V[i];
      end
    end
    mapped = |sel_oh;
  end
  always_comb begin
    state_d    = state_q;
    cur_sel_d  = cur_sel_q;
    rd_addr_d  = rd_addr_q;
    wait_cnt_d = wait_cnt_q;
    rd_data_d  = rd_data_q;
    rd_v_d     = 1'b0;
    rd_go      = 1'b0;
    inc_to     = 1'b0;
    inc_um     = lwen_q && !mapped;
    // A read loses to a simultaneous write and is refused while another read waits.
    rd_ok      = lren_q && !lwen_q;
    inc_dr     = lren_q && (lwen_q || state_q == WAIT);
    if (state_q == IDLE) begin
      if (rd_ok && mapped) begin
        rd_go     = 1'b1;
        cur_sel_d = sel;
        rd_addr_d = laddr_q;
        if (sel_v) begin
          rd_data_d = sel_data;
          rd_v_d    = 1'b1;
        end else begin
          state_d    = WAIT;
          wait_cnt_d = 16'd1;
        end
      end else if (rd_ok) begin
        rd_data_d = resp_word(32'h5555_AAAA, laddr_q);
        rd_v_d    = 1'b1;
        inc_um    = 1'b1;
      end
    end else begin
      // The valid is checked first so a response in the last allowed cycle beats the timeout.
      if (cur_v) begin
        rd_data_d = cur_data;
        rd_v_d    = 1'b1;
        state_d   = IDLE;
      end else if (wait_cnt_q == 16'(TIMEOUT - 1)) begin
        rd_data_d = resp_word(32'hDEAD_BEEF, rd_addr_q);
        rd_v_d    = 1'b1;
        inc_to    = 1'b1;
        state_d   = IDLE;
      end else begin
        wait_cnt_d = wait_cnt_q + 16'd1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      laddr_q    <= '0;
      lwen_q     <= 1'b0;
      lren_q     <= 1'b0;
      lwdata_q   <= '0;
      rd_addr_q  <= '0;
      cur_sel_q  <= '0;
      wait_cnt_q <= '0;
      rd_data_q  <= '0;
      rd_v_q     <= 1'b0;
      to_cnt_q   <= '0;
      um_cnt_q   <= '0;
      dr_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      laddr_q    <= iMM_ADDR;
      lwen_q     <= iMM_WR_EN;
      lren_q     <= iMM_RD_EN;
      lwdata_q   <= iMM_WR_DATA;
      rd_addr_q  <= rd_addr_d;
      cur_sel_q  <= cur_sel_d;
      wait_cnt_q <= wait_cnt_d;
      rd_data_q  <= rd_data_d;
      rd_v_q     <= rd_v_d;
      to_cnt_q   <= sat_inc(to_cnt_q, inc_to);
      um_cnt_q   <= sat_inc(um_cnt_q, inc_um);
      dr_cnt_q   <= sat_inc(dr_cnt_q, inc_dr);
    end
  end
  assign oMM_RD_DATA       = rd_data_q;
  assign oMM_RD_DATA_V     = rd_v_q;
  assign oMM_BUSY          = (state_q == WAIT);
  assign oCH_ADDR          = laddr_q;
  assign oCH_WR_DATA       = lwdata_q;
  assign oCH_WR_EN         = lwen_q ? sel_oh : '0;
  assign oCH_RD_EN         = rd_go ? sel_oh : '0;
  assign oERR_TIMEOUT_CNT  = to_cnt_q;
  assign oERR_UNMAPPED_CNT = um_cnt_q;
  assign oERR_DROP_CNT     = dr_cnt_q;
endmodule

// File: tb/tb_mm_addr_decoder_n.sv
// tb_mm_addr_decoder_n: directed self-checking bench for mm_addr_decoder_n
module tb_mm_addr_decoder_n;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_en, rd_en;
  logic [16:0]  addr;
  logic [63:0]  wdata;
  logic [63:0]  rd_data;
  logic         rd_v, busy;
  logic [16:0]  ch_addr;
  logic [63:0]  ch_wdata;
  logic [3:0]   ch_wr, ch_rd, ch_v;
  logic [255:0] ch_data;
  logic [15:0]  to_cnt, um_cnt, dr_cnt;
  int n_cmp = 0;
  int n_err = 0;
  mm_addr_decoder_n #(.NUM_CH(4), .AW(17), .DW(64), .SEL_W(3), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .iMM_WR_EN(wr_en), .iMM_RD_EN(rd_en), .iMM_ADDR(addr), .iMM_WR_DATA(wdata),
    .oMM_RD_DATA(rd_data), .oMM_RD_DATA_V(rd_v), .oMM_BUSY(busy),
    .oCH_ADDR(ch_addr), .oCH_WR_DATA(ch_wdata), .oCH_WR_EN(ch_wr), .oCH_RD_EN(ch_rd),
    .iCH_RD_DATA(ch_data), .iCH_RD_DATA_V(ch_v),
    .oERR_TIMEOUT_CNT(to_cnt), .oERR_UNMAPPED_CNT(um_cnt), .oERR_DROP_CNT(dr_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_data"}, rd_data, 64'h0);
    chk({tag, "_rd_v"}, rd_v, 64'h0);
    chk({tag, "_busy"}, busy, 64'h0);
    chk({tag, "_ch_addr"}, ch_addr, 64'h0);
    chk({tag, "_ch_wdata"}, ch_wdata, 64'h0);
    chk({tag, "_ch_wr"}, ch_wr, 64'h0);
    chk({tag, "_ch_rd"}, ch_rd, 64'h0);
    chk({tag, "_to_cnt"}, to_cnt, 64'h0);
    chk({tag, "_um_cnt"}, um_cnt, 64'h0);
    chk({tag, "_dr_cnt"}, dr_cnt, 64'h0);
  endtask
  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0; ch_v = '0; ch_data = '0;
    tick(); tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
    // write to channel 2
    wr_en = 1'b1; addr = 17'h08010; wdata = 64'h1234;
    tick();
    wr_en = 1'b0;
    chk("wr_strobe", ch_wr, 64'h4);
    chk("wr_addr", ch_addr, 64'h08010);
    chk("wr_data", ch_wdata, 64'h1234);
    chk("wr_no_rd", ch_rd, 64'h0);
    chk("wr_no_v1", rd_v, 64'h0);
    tick();
    chk("wr_strobe_off", ch_wr, 64'h0);
    chk("wr_no_v2", rd_v, 64'h0);
    // read ch0, response at cycle 3; a foreign valid at cycle 2 is ignored
    rd_en = 1'b1; addr = 17'h00040;
    tick();
    rd_en = 1'b0;
    chk("rd0_strobe", ch_rd, 64'h1);
    tick();
    chk("rd0_busy_c2", busy, 64'h1);
    ch_v[2] = 1'b1; ch_data[128 +: 64] = 64'hBAD;
    tick();
    ch_v = '0;
    chk("rd0_ignore_other", rd_v, 64'h0);
    chk("rd0_busy_c3", busy, 64'h1);
    ch_v[0] = 1'b1; ch_data[0 +: 64] = 64'hA5;
    tick();
    ch_v = '0;
    chk("rd0_v_c4", rd_v, 64'h1);
    chk("rd0_data", rd_data, 64'hA5);
    chk("rd0_busy_c4", busy, 64'h0);
    tick();
    chk("rd0_v_pulse", rd_v, 64'h0);
    chk("rd0_data_hold", rd_data, 64'hA5);
    // read ch3 with same-cycle response
    rd_en = 1'b1; addr = 17'h0C008;
    tick();
    rd_en = 1'b0;
    chk("rd3_strobe", ch_rd, 64'h8);
    ch_v[3] = 1'b1; ch_data[192 +: 64] = 64'hC3C3;
    tick();
    ch_v = '0;
    chk("rd3_v_c2", rd_v, 64'h1);
    chk("rd3_data", rd_data, 64'hC3C3);
    chk("rd3_busy", busy, 64'h0);
    // unmapped read
    rd_en = 1'b1; addr = 17'h1C005;
    tick();
    rd_en = 1'b0;
    chk("um_no_strobe", ch_rd, 64'h0);
    chk("um_no_v_c1", rd_v, 64'h0);
    tick();
    chk("um_v_c2", rd_v, 64'h1);
    chk("um_data", rd_data, 64'h5555AAAA_0001C005);
    chk("um_cnt1", um_cnt, 64'h1);
    chk("um_busy", busy, 64'h0);
    // timeout on ch1, then late valid at cycle 12
    rd_en = 1'b1; addr = 17'h04020;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c == 1) rd_en = 1'b0;
      if (c == 1) chk("to_strobe", ch_rd, 64'h2);
      if (c == 12) ch_v[1] = 1'b1;
      if (c == 13) ch_v = '0;
      chk($sformatf("to_v_c%0d", c), rd_v, {63'b0, c == 9});
      chk($sformatf("to_busy_c%0d", c), busy, {63'b0, c >= 2 && c <= 8});
      if (c >= 9) chk($sformatf("to_data_c%0d", c), rd_data, 64'hDEADBEEF_00004020);
      if (c == 9) chk("to_cnt1", to_cnt, 64'h1);
    end
    // second read while ch0 outstanding is dropped
    rd_en = 1'b1; addr = 17'h00100;
    tick();
    addr = 17'h08000;
    chk("dr_first_strobe", ch_rd, 64'h1);
    tick();
    rd_en = 1'b0;
    chk("dr_no_strobe", ch_rd, 64'h0);
    chk("dr_busy", busy, 64'h1);
    tick();
    chk("dr_cnt1", dr_cnt, 64'h1);
    ch_v[0] = 1'b1; ch_data[0 +: 64] = 64'h77;
    tick();
    ch_v = '0;
    chk("dr_first_v", rd_v, 64'h1);
    chk("dr_first_data", rd_data, 64'h77);
    tick();
    chk("dr_no_second_v", rd_v, 64'h0);
    chk("dr_to_cnt_same", to_cnt, 64'h1);
    // write and read together
    wr_en = 1'b1; rd_en = 1'b1; addr = 17'h04008; wdata = 64'hBEEF;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("cf_wr_strobe", ch_wr, 64'h2);
    chk("cf_no_rd", ch_rd, 64'h0);
    chk("cf_wdata", ch_wdata, 64'hBEEF);
    tick();
    chk("cf_dr_cnt2", dr_cnt, 64'h2);
    chk("cf_no_v", rd_v, 64'h0);
    chk("cf_busy", busy, 64'h0);
    // unmapped write is discarded and counted
    wr_en = 1'b1; addr = 17'h14000; wdata = 64'h99;
    tick();
    wr_en = 1'b0;
    chk("umw_no_strobe", ch_wr, 64'h0);
    tick();
    chk("umw_cnt2", um_cnt, 64'h2);
    // reset during WAIT aborts the read
    rd_en = 1'b1; addr = 17'h08040;
    tick();
    rd_en = 1'b0;
    chk("rw_strobe", ch_rd, 64'h4);
    tick();
    chk("rw_busy", busy, 64'h1);
    tick();
    rst_n = 1'b0;
    #1;
    chk_all_zero("rw_reset");
    tick();
    rst_n = 1'b1;
    tick();
    ch_v[2] = 1'b1; ch_data[128 +: 64] = 64'hFACE;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (c == 1) ch_v = '0;
      chk($sformatf("rw_no_v_%0d", c), rd_v, 64'h0);
      chk($sformatf("rw_no_busy_%0d", c), busy, 64'h0);
    end
    chk("rw_data_zero", rd_data, 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
